// File: rtl/ifm_buf_ctrl_if.sv
// ifm_buf_ctrl_if: IFM SRAM read bus, line-buffer strobes/mode and PE-array window handshake.
// The controller drives through the master modport; the line buffer / SRAM / PE side uses the slave modport.
interface ifm_buf_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DIM_WIDTH  = 8
);
    logic [2:0]            mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [2:0]            ifm_read;
    logic [1:0]            mode;
    logic                  win_valid;
    logic                  win_ready;
    logic [DIM_WIDTH-1:0]  win_row;

    modport master (
        output mem_rd_en, mem_rd_addr, ifm_read, mode, win_valid, win_row,
        input  win_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, ifm_read, mode, win_valid, win_row,
        output win_ready
    );
endinterface

// File: rtl/ifm_buf_ctrl.sv
// ifm_buf_ctrl: sequences 3-bank IFM SRAM reads into the 3-row line buffer and offers 3x3 windows.
// Optional macro IFM_BUF_CTRL_PERF_EN adds the perf_stall_cnt window-stall counter.
module ifm_buf_ctrl #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DIM_WIDTH  = 8,
    parameter int unsigned SRAM_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            cfg_mode,
    input  logic [DIM_WIDTH-1:0]  cfg_rows,
    input  logic [DIM_WIDTH-1:0]  cfg_tiles,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [ADDR_WIDTH-1:0] cfg_row_stride,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    ifm_buf_ctrl_if.master        bus
`ifdef IFM_BUF_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt
`endif
);

    localparam int unsigned WAIT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WAIT,
        S_WIN,
        S_SLIDE,
        S_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [2:0]                   rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic [DIM_WIDTH-1:0]         tile_q, tile_d;
    logic [DIM_WIDTH-1:0]         nrow_q, nrow_d;
    logic [1:0]                   nmod_q, nmod_d;
    logic [ADDR_WIDTH-1:0]        roff_q, roff_d;
    logic [WAIT_W-1:0]            wcnt_q, wcnt_d;
    logic                         cfg_err_d;
    logic                         latch_cfg;
    logic [DIM_WIDTH-1:0]         rows_q, tiles_q;
    logic [ADDR_WIDTH-1:0]        base_q, stride_q;
    logic [1:0]                   mode_q;
    logic                         busy_q, done_q, cfg_err_q;
    logic                         win_valid_q;
    logic [DIM_WIDTH-1:0]         win_row_q;
    logic [SRAM_LAT-1:0][2:0]     rd_pipe;

    // Next-state, read issue and incremental row/bank/offset counters (r/3 and r mod 3 without a divider)
    always_comb begin
        state_d   = state_q;
        rd_en_d   = 3'b000;
        addr_d    = addr_q;
        tile_d    = tile_q;
        nrow_d    = nrow_q;
        nmod_d    = nmod_q;
        roff_d    = roff_q;
        wcnt_d    = wcnt_q;
        cfg_err_d = 1'b0;
        latch_cfg = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_rows < DIM_WIDTH'(3) || cfg_tiles == '0) begin
                        state_d   = S_DONE;
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d   = S_FILL;
                        latch_cfg = 1'b1;
                        tile_d    = '0;
                        rd_en_d   = 3'b111;
                        addr_d    = cfg_base;
                        nrow_d    = DIM_WIDTH'(3);
                        nmod_d    = 2'd0;
                        roff_d    = cfg_row_stride;
                    end
                end
            end
            S_FILL, S_SLIDE: begin
                state_d = S_WAIT;
                wcnt_d  = WAIT_W'(SRAM_LAT - 1);
            end
            S_WAIT: begin
                if (wcnt_q == '0) state_d = S_WIN;
                else              wcnt_d  = wcnt_q - WAIT_W'(1);
            end
            S_WIN: begin
                if (bus.win_ready) begin
                    if (nrow_q < rows_q) begin
                        state_d = S_SLIDE;
                        rd_en_d = 3'b001 << nmod_q;
                        addr_d  = base_q + roff_q + ADDR_WIDTH'(tile_q);
                        nrow_d  = nrow_q + DIM_WIDTH'(1);
                        if (nmod_q == 2'd2) begin
                            nmod_d = 2'd0;
                            roff_d = roff_q + stride_q;
                        end else begin
                            nmod_d = nmod_q + 2'd1;
                        end
                    end else if (tile_q < tiles_q - DIM_WIDTH'(1)) begin
                        state_d = S_FILL;
                        tile_d  = tile_q + DIM_WIDTH'(1);
                        rd_en_d = 3'b111;
                        addr_d  = base_q + ADDR_WIDTH'(tile_q + DIM_WIDTH'(1));
                        nrow_d  = DIM_WIDTH'(3);
                        nmod_d  = 2'd0;
                        roff_d  = stride_q;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered outputs (outputs follow the state being entered)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_en_q     <= '0;
            addr_q      <= '0;
            tile_q      <= '0;
            nrow_q      <= '0;
            nmod_q      <= '0;
            roff_q      <= '0;
            wcnt_q      <= '0;
            rows_q      <= '0;
            tiles_q     <= '0;
            base_q      <= '0;
            stride_q    <= '0;
            mode_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
        end else begin
            state_q     <= state_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            tile_q      <= tile_d;
            nrow_q      <= nrow_d;
            nmod_q      <= nmod_d;
            roff_q      <= roff_d;
            wcnt_q      <= wcnt_d;
            busy_q      <= (state_d inside {S_FILL, S_WAIT, S_WIN, S_SLIDE});
            done_q      <= (state_d == S_DONE);
            cfg_err_q   <= cfg_err_d;
            win_valid_q <= (state_d == S_WIN);
            if (state_d == S_WIN) win_row_q <= nrow_q - DIM_WIDTH'(3);
            if (latch_cfg) begin
                rows_q   <= cfg_rows;
                tiles_q  <= cfg_tiles;
                base_q   <= cfg_base;
                stride_q <= cfg_row_stride;
                mode_q   <= cfg_mode;
            end
        end
    end

    // Row-load strobes: read enables delayed by the SRAM latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= rd_en_q;
            for (int i = 1; i < int'(SRAM_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

`ifdef IFM_BUF_CTRL_PERF_EN
    logic [31:0] stall_q;

    // Saturating count of cycles a window waits on the PE array
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          stall_q <= '0;
        else if (state_q == S_IDLE && start)                 stall_q <= '0;
        else if (win_valid_q && !bus.win_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
    end

    assign perf_stall_cnt = stall_q;
`endif

    assign busy            = busy_q;
    assign done            = done_q;
    assign cfg_err         = cfg_err_q;
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_rd_addr = addr_q;
    assign bus.ifm_read    = rd_pipe[SRAM_LAT-1];
    assign bus.mode        = mode_q;
    assign bus.win_valid   = win_valid_q;
    assign bus.win_row     = win_row_q;

endmodule

// File: tb/tb_ifm_buf_ctrl.sv
// tb_ifm_buf_ctrl: directed-vector bench for ifm_buf_ctrl (SRAM_LAT=1 instance plus an SRAM_LAT=3 instance).
module tb_ifm_buf_ctrl;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          start3 = 1'b0;
    logic [1:0]    cfg_mode = '0;
    logic [DW-1:0] cfg_rows = '0;
    logic [DW-1:0] cfg_tiles = '0;
    logic [AW-1:0] cfg_base = '0;
    logic [AW-1:0] cfg_row_stride = '0;
    logic          busy, done, cfg_err;
    logic          busy3, done3, cfg_err3;
`ifdef IFM_BUF_CTRL_PERF_EN
    logic [31:0]   perf, perf3;
`endif
    int vectors = 0;
    int errors  = 0;

    ifm_buf_ctrl_if #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW)) bus ();
    ifm_buf_ctrl_if #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW)) bus3 ();

    always #5 clk = ~clk;

    ifm_buf_ctrl #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW), .SRAM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode), .cfg_rows(cfg_rows),
        .cfg_tiles(cfg_tiles), .cfg_base(cfg_base), .cfg_row_stride(cfg_row_stride),
        .busy(busy), .done(done), .cfg_err(cfg_err), .bus(bus)
`ifdef IFM_BUF_CTRL_PERF_EN
        , .perf_stall_cnt(perf)
`endif
    );

    ifm_buf_ctrl #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW), .SRAM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .cfg_mode(cfg_mode), .cfg_rows(cfg_rows),
        .cfg_tiles(cfg_tiles), .cfg_base(cfg_base), .cfg_row_stride(cfg_row_stride),
        .busy(busy3), .done(done3), .cfg_err(cfg_err3), .bus(bus3)
`ifdef IFM_BUF_CTRL_PERF_EN
        , .perf_stall_cnt(perf3)
`endif
    );

    // Apply a configuration and a one-cycle start; returns at the first cycle after acceptance
    task automatic kick(input logic [1:0] m, input logic [DW-1:0] rows, input logic [DW-1:0] tiles,
                        input logic [AW-1:0] base, input logic [AW-1:0] stride, input bit sel3);
        cfg_mode       = m;
        cfg_rows       = rows;
        cfg_tiles      = tiles;
        cfg_base       = base;
        cfg_row_stride = stride;
        if (sel3) start3 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({busy, done, cfg_err, bus.mem_rd_en, bus.mem_rd_addr, bus.ifm_read, bus.mode,
             bus.win_valid, bus.win_row} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {busy, done, cfg_err, bus.mem_rd_en,
                     bus.mem_rd_addr, bus.ifm_read, bus.mode, bus.win_valid, bus.win_row});
        end
        vectors++;
        if ({busy3, done3, cfg_err3, bus3.mem_rd_en, bus3.ifm_read, bus3.win_valid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_lat3 got %h want 0",
                     {busy3, done3, cfg_err3, bus3.mem_rd_en, bus3.ifm_read, bus3.win_valid});
        end
`ifdef IFM_BUF_CTRL_PERF_EN
        vectors++;
        if (perf !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf got %0d want 0", perf);
        end
`endif
    endtask

    task automatic test_single_tile();
        logic [2:0]    e_rd[10]   = '{3'b111, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000};
        logic [2:0]    e_ifm[10]  = '{3'b000, 3'b111, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000};
        logic [AW-1:0] e_addr[10] = '{12'h100, 12'h100, 12'h100, 12'h110, 12'h110, 12'h110, 12'h110, 12'h110, 12'h110, 12'h110};
        logic [DW-1:0] e_row[10]  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd2, 8'd0};
        logic [0:9]    e_wv       = 10'b0010010010;
        logic [0:9]    e_done     = 10'b0000000001;
        bus.win_ready = 1'b1;
        kick(2'd1, 8'd5, 8'd1, 12'h100, 12'h010, 1'b0);
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if ({bus.mem_rd_en, bus.ifm_read} !== {e_rd[c], e_ifm[c]}) begin
                errors++;
                $display("FAIL single c%0d rd_ifm got %b_%b want %b_%b", c, bus.mem_rd_en, bus.ifm_read, e_rd[c], e_ifm[c]);
            end
            vectors++;
            if (bus.mem_rd_addr !== e_addr[c]) begin
                errors++;
                $display("FAIL single c%0d addr got %h want %h", c, bus.mem_rd_addr, e_addr[c]);
            end
            vectors++;
            if ({bus.win_valid, done, busy, cfg_err} !== {e_wv[c], e_done[c], ~e_done[c], 1'b0}) begin
                errors++;
                $display("FAIL single c%0d wv_done_busy_err got %b want %b", c,
                         {bus.win_valid, done, busy, cfg_err}, {e_wv[c], e_done[c], ~e_done[c], 1'b0});
            end
            if (e_wv[c]) begin
                vectors++;
                if (bus.win_row !== e_row[c]) begin
                    errors++;
                    $display("FAIL single c%0d win_row got %0d want %0d", c, bus.win_row, e_row[c]);
                end
            end
            // A start while busy must be ignored and must not relatch the configuration
            if (c == 4) begin
                start    = 1'b1;
                cfg_mode = 2'd2;
                cfg_base = 12'h3F0;
            end
            if (c == 5) start = 1'b0;
            @(negedge clk);
        end
        vectors++;
        if ({bus.mode, busy, done} !== {2'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_after mode_busy_done got %b want %b", {bus.mode, busy, done}, {2'd1, 1'b0, 1'b0});
        end
    endtask

    task automatic test_multi_tile();
        logic [2:0]    e_rd[13]   = '{3'b111, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000,
                                      3'b111, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
        logic [2:0]    e_ifm[13]  = '{3'b000, 3'b111, 3'b000, 3'b000, 3'b001, 3'b000,
                                      3'b000, 3'b111, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
        logic [AW-1:0] e_addr[13] = '{12'h000, 12'h000, 12'h000, 12'h008, 12'h008, 12'h008,
                                      12'h001, 12'h001, 12'h001, 12'h009, 12'h009, 12'h009, 12'h009};
        logic [DW-1:0] e_row[13]  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1,
                                      8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0};
        logic [0:12]   e_wv       = 13'b0010010010010;
        logic [0:12]   e_done     = 13'b0000000000001;
        bus.win_ready = 1'b1;
        kick(2'd3, 8'd4, 8'd2, 12'h000, 12'h008, 1'b0);
        for (int c = 0; c < 13; c++) begin
            vectors++;
            if ({bus.mem_rd_en, bus.ifm_read} !== {e_rd[c], e_ifm[c]}) begin
                errors++;
                $display("FAIL multi c%0d rd_ifm got %b_%b want %b_%b", c, bus.mem_rd_en, bus.ifm_read, e_rd[c], e_ifm[c]);
            end
            vectors++;
            if (bus.mem_rd_addr !== e_addr[c]) begin
                errors++;
                $display("FAIL multi c%0d addr got %h want %h", c, bus.mem_rd_addr, e_addr[c]);
            end
            vectors++;
            if ({bus.win_valid, done, busy} !== {e_wv[c], e_done[c], ~e_done[c]}) begin
                errors++;
                $display("FAIL multi c%0d wv_done_busy got %b want %b", c,
                         {bus.win_valid, done, busy}, {e_wv[c], e_done[c], ~e_done[c]});
            end
            if (e_wv[c]) begin
                vectors++;
                if (bus.win_row !== e_row[c]) begin
                    errors++;
                    $display("FAIL multi c%0d win_row got %0d want %0d", c, bus.win_row, e_row[c]);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if ({done, busy, bus.mode} !== {1'b0, 1'b0, 2'd3}) begin
            errors++;
            $display("FAIL multi_after done_busy_mode got %b want %b", {done, busy, bus.mode}, {1'b0, 1'b0, 2'd3});
        end
    endtask

    task automatic test_stall();
        logic [0:8] e_wv   = 9'b001111110;
        logic [0:8] e_done = 9'b000000001;
        bus.win_ready = 1'b0;
        kick(2'd2, 8'd3, 8'd1, 12'h040, 12'h004, 1'b0);
        for (int c = 0; c < 9; c++) begin
            vectors++;
            if ({bus.mem_rd_en, bus.ifm_read} !== {(c == 0) ? 3'b111 : 3'b000, (c == 1) ? 3'b111 : 3'b000}) begin
                errors++;
                $display("FAIL stall c%0d rd_ifm got %b_%b", c, bus.mem_rd_en, bus.ifm_read);
            end
            vectors++;
            if ({bus.win_valid, done, busy, bus.mem_rd_addr} !== {e_wv[c], e_done[c], ~e_done[c], 12'h040}) begin
                errors++;
                $display("FAIL stall c%0d wv_done_busy_addr got %b_%b_%b_%h want %b_%b_%b_040", c,
                         bus.win_valid, done, busy, bus.mem_rd_addr, e_wv[c], e_done[c], ~e_done[c]);
            end
            if (e_wv[c]) begin
                vectors++;
                if (bus.win_row !== 8'd0) begin
                    errors++;
                    $display("FAIL stall c%0d win_row got %0d want 0", c, bus.win_row);
                end
            end
`ifdef IFM_BUF_CTRL_PERF_EN
            if (e_done[c]) begin
                vectors++;
                if (perf !== 32'd5) begin
                    errors++;
                    $display("FAIL stall perf_at_done got %0d want 5", perf);
                end
            end
`endif
            if (c == 7) bus.win_ready = 1'b1;
            @(negedge clk);
        end
`ifdef IFM_BUF_CTRL_PERF_EN
        vectors++;
        if (perf !== 32'd5) begin
            errors++;
            $display("FAIL stall perf_hold got %0d want 5", perf);
        end
`endif
    endtask

    task automatic test_cfg_err();
        for (int k = 0; k < 2; k++) begin
            kick(2'd0, (k == 0) ? 8'd2 : 8'd5, (k == 0) ? 8'd1 : 8'd0, 12'h100, 12'h010, 1'b0);
            vectors++;
            if ({done, cfg_err, busy, bus.mem_rd_en} !== {1'b1, 1'b1, 1'b0, 3'b000}) begin
                errors++;
                $display("FAIL cfg_err%0d first got %b want 1100", k, {done, cfg_err, busy, bus.mem_rd_en});
            end
            @(negedge clk);
            vectors++;
            if ({done, cfg_err, busy, bus.mem_rd_en, bus.ifm_read} !== {1'b0, 1'b0, 1'b0, 3'b000, 3'b000}) begin
                errors++;
                $display("FAIL cfg_err%0d second got %b want 0", k, {done, cfg_err, busy, bus.mem_rd_en, bus.ifm_read});
            end
        end
    endtask

    task automatic test_lat3();
        logic [0:5] e_rd   = 6'b100000;
        logic [0:5] e_ifm  = 6'b000100;
        logic [0:5] e_wv   = 6'b000010;
        logic [0:5] e_done = 6'b000001;
        bus3.win_ready = 1'b1;
        kick(2'd1, 8'd3, 8'd1, 12'h200, 12'h010, 1'b1);
        for (int c = 0; c < 6; c++) begin
            vectors++;
            if ({bus3.mem_rd_en, bus3.ifm_read, bus3.win_valid, done3, busy3} !==
                {{3{e_rd[c]}}, {3{e_ifm[c]}}, e_wv[c], e_done[c], ~e_done[c]}) begin
                errors++;
                $display("FAIL lat3 c%0d rd_ifm_wv_done_busy got %b want %b", c,
                         {bus3.mem_rd_en, bus3.ifm_read, bus3.win_valid, done3, busy3},
                         {{3{e_rd[c]}}, {3{e_ifm[c]}}, e_wv[c], e_done[c], ~e_done[c]});
            end
            vectors++;
            if (bus3.mem_rd_addr !== 12'h200) begin
                errors++;
                $display("FAIL lat3 c%0d addr got %h want 200", c, bus3.mem_rd_addr);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midrun();
        bus.win_ready = 1'b1;
        kick(2'd3, 8'd4, 8'd2, 12'h000, 12'h008, 1'b0);
        repeat (7) @(negedge clk);
        vectors++;
        if ({bus.ifm_read, bus.mem_rd_addr, busy} !== {3'b111, 12'h001, 1'b1}) begin
            errors++;
            $display("FAIL midrun_tile1_wait got %b_%h_%b want 111_001_1", bus.ifm_read, bus.mem_rd_addr, busy);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, cfg_err, bus.mem_rd_en, bus.mem_rd_addr, bus.ifm_read, bus.mode,
             bus.win_valid, bus.win_row} !== '0) begin
            errors++;
            $display("FAIL midrun_reset got %h want 0", {busy, done, cfg_err, bus.mem_rd_en,
                     bus.mem_rd_addr, bus.ifm_read, bus.mode, bus.win_valid, bus.win_row});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        kick(2'd1, 8'd3, 8'd1, 12'h020, 12'h008, 1'b0);
        vectors++;
        if ({bus.mem_rd_en, bus.mem_rd_addr, busy} !== {3'b111, 12'h020, 1'b1}) begin
            errors++;
            $display("FAIL restart_fill got %b_%h_%b want 111_020_1", bus.mem_rd_en, bus.mem_rd_addr, busy);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.win_valid, bus.win_row} !== {1'b1, 8'd0}) begin
            errors++;
            $display("FAIL restart_win got %b_%0d want 1_0", bus.win_valid, bus.win_row);
        end
        @(negedge clk);
        vectors++;
        if ({done, cfg_err, busy, bus.win_valid} !== {1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL restart_done got %b want 1000", {done, cfg_err, busy, bus.win_valid});
        end
        @(negedge clk);
    endtask

    initial begin
        bus.win_ready  = 1'b1;
        bus3.win_ready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_single_tile();
        test_multi_tile();
        test_stall();
        test_cfg_err();
        test_lat3();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
